branch_ctrl: RTL and testbench

Branch resolution controller for the EX stage of the 5-stage RV32I pipeline. It drives the branch comparator's signedness select and decodes funct3 together with the comparator's eq/lt results into a taken/not-taken decision. On a taken branch or jump it sequences the redirect handshake with the fetch unit and a bounded squash window, so wrong-path instructions are killed.

---
 rtl/branch_pkg.sv | 19 +
 rtl/branch_decide.sv | 36 +++
 rtl/branch_ctrl.sv | 150 +++++++++++++++
 tb/tb_branch_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the EX-stage branch resolution controller.
// Holds the RV32I branch funct3 encodings and the redirect/squash FSM state type.
// No logic here; imported by branch_decide and branch_ctrl.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } br_state_t;

endpackage

// File: rtl/branch_decide.sv
// Branch decision: funct3 + comparator eq/lt + jump -> taken / reserved-encoding flag.
// Latency: purely combinational, zero cycles.
// Backpressure: none; qualification by valid/stall/FSM state happens in the caller.
module branch_decide
  import branch_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       eq_i,
  input  logic       lt_i,
  input  logic       jump_i,
  output logic       taken_o,
  output logic       illegal_o
);

  // Decode funct3 into a taken decision; jumps override everything.
  // The comparator already applies signedness via br_un, so BLT/BLTU
  // and BGE/BGEU share the same lt polarity here.
  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    unique case (funct3_i)
      F3_BEQ:  taken_o = eq_i;
      F3_BNE:  taken_o = !eq_i;
      F3_BLT:  taken_o = lt_i;
      F3_BGE:  taken_o = !lt_i;
      F3_BLTU: taken_o = lt_i;
      F3_BGEU: taken_o = !lt_i;
      default: illegal_o = 1'b1;
    endcase
    if (jump_i) begin
      taken_o   = 1'b1;
      illegal_o = 1'b0;
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// EX-stage branch controller: resolves branches/jumps, issues fetch redirect, squashes wrong path.
// Latency: squash same cycle as resolution; redirect_valid one cycle later; FLUSH_DEPTH squash cycles after accept.
// Backpressure: redirect held stable until redirect_ready; stall blocks resolution only in IDLE.
// Optional: define BRANCH_CTRL_STATS_EN to build the br_total/br_taken counters (else tied to 0).
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic             ex_jump,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             stall,
  input  logic             eq,
  input  logic             lt,
  output logic             br_un,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             squash,
  output logic             br_illegal,
  output logic [CNT_W-1:0] br_total,
  output logic [CNT_W-1:0] br_taken
);

  localparam int CW = (FLUSH_DEPTH < 2) ? 1 : $clog2(FLUSH_DEPTH + 1);

  br_state_t       state_q, state_d;
  logic            rv_q, rv_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ill_q, ill_d;

  logic taken;
  logic illegal;
  logic resolve;

  branch_decide u_decide (
    .funct3_i  (ex_funct3),
    .eq_i      (eq),
    .lt_i      (lt),
    .jump_i    (ex_jump),
    .taken_o   (taken),
    .illegal_o (illegal)
  );

  // funct3[1] distinguishes BLTU/BGEU from BLT/BGE; driven for every encoding.
  assign br_un = ex_funct3[1];

  // Anything arriving while the FSM is busy is wrong-path and never resolves.
  assign resolve = ex_valid & !stall & (ex_branch | ex_jump) & (state_q == IDLE);

  assign squash         = (resolve & taken) | (state_q != IDLE);
  assign redirect_valid = rv_q;
  assign redirect_pc    = pc_q;
  assign br_illegal     = ill_q;

  // Next-state logic for the redirect handshake and bounded squash window.
  always_comb begin
    state_d = state_q;
    rv_d    = rv_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    ill_d   = resolve & ex_branch & illegal;
    unique case (state_q)
      IDLE: begin
        if (resolve && taken) begin
          state_d = REDIRECT;
          rv_d    = 1'b1;
          pc_d    = ex_target;
        end
      end
      REDIRECT: begin
        if (redirect_ready) begin
          rv_d = 1'b0;
          if (FLUSH_DEPTH == 0) begin
            state_d = IDLE;
          end else begin
            state_d = FLUSH;
            cnt_d   = CW'(FLUSH_DEPTH);
          end
        end
      end
      FLUSH: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        rv_d    = 1'b0;
      end
    endcase
  end

  // State and handshake registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rv_q    <= 1'b0;
      pc_q    <= '0;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rv_q    <= rv_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
    end
  end

`ifdef BRANCH_CTRL_STATS_EN
  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] taken_q, taken_d;

  // Statistics: conditional branches resolved, and all taken branches/jumps; wrap naturally.
  always_comb begin
    total_d = total_q;
    taken_d = taken_q;
    if (resolve && ex_branch && !ex_jump) total_d = total_q + CNT_W'(1);
    if (resolve && taken)                 taken_d = taken_q + CNT_W'(1);
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      total_q <= '0;
      taken_q <= '0;
    end else begin
      total_q <= total_d;
      taken_q <= taken_d;
    end
  end

  assign br_total = total_q;
  assign br_taken = taken_q;
`else
  assign br_total = '0;
  assign br_taken = '0;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed testbench for branch_ctrl with hand-computed expectations.
// Inputs change 1ns after the rising edge; outputs are checked mid-cycle.
// Counter expectations collapse to 0 when BRANCH_CTRL_STATS_EN is not defined.
module tb_branch_ctrl;

  localparam int XLEN  = 32;
  localparam int CNT_W = 32;

`ifdef BRANCH_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ex_valid, ex_branch, ex_jump;
  logic [2:0]       ex_funct3;
  logic [XLEN-1:0]  ex_target;
  logic             stall, eq, lt;
  logic             br_un, redirect_valid, redirect_ready;
  logic [XLEN-1:0]  redirect_pc;
  logic             squash, br_illegal;
  logic [CNT_W-1:0] br_total, br_taken;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_ctrl #(.XLEN(XLEN), .FLUSH_DEPTH(2), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_valid       (ex_valid),
    .ex_branch      (ex_branch),
    .ex_jump        (ex_jump),
    .ex_funct3      (ex_funct3),
    .ex_target      (ex_target),
    .stall          (stall),
    .eq             (eq),
    .lt             (lt),
    .br_un          (br_un),
    .redirect_valid (redirect_valid),
    .redirect_ready (redirect_ready),
    .redirect_pc    (redirect_pc),
    .squash         (squash),
    .br_illegal     (br_illegal),
    .br_total       (br_total),
    .br_taken       (br_taken)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock and settle 1ns past the edge before driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle mid-cycle before checking.
  task automatic settle();
    #3;
  endtask

  task automatic chk_cnt(input string tag, input int total, input int tkn);
    chk({tag, "_total"}, 64'(br_total), STATS ? 64'(total) : 64'd0);
    chk({tag, "_taken"}, 64'(br_taken), STATS ? 64'(tkn) : 64'd0);
  endtask

  initial begin
    logic [2:0] f3;
    rst_n = 1'b0; ex_valid = 1'b0; ex_branch = 1'b0; ex_jump = 1'b0;
    ex_funct3 = 3'b000; ex_target = '0; stall = 1'b0; eq = 1'b0; lt = 1'b0;
    redirect_ready = 1'b0;

    // Reset state
    step(); step(); settle();
    chk("rst_rv", 64'(redirect_valid), 64'd0);
    chk("rst_pc", 64'(redirect_pc), 64'd0);
    chk("rst_squash", 64'(squash), 64'd0);
    chk("rst_ill", 64'(br_illegal), 64'd0);
    chk_cnt("rst", 0, 0);
    step();
    rst_n = 1'b1;

    // br_un follows funct3[1] for all encodings
    for (int i = 0; i < 8; i++) begin
      f3 = 3'(i);
      ex_funct3 = f3;
      #1;
      chk("br_un_sweep", 64'(br_un), 64'(f3[1]));
    end

    // BEQ taken, fetch ready immediately
    step();
    ex_valid = 1'b1; ex_branch = 1'b1; ex_funct3 = 3'b000; eq = 1'b1;
    ex_target = 32'h0000_0040; redirect_ready = 1'b1;
    settle();
    chk("beq_sq_N", 64'(squash), 64'd1);
    chk("beq_rv_N", 64'(redirect_valid), 64'd0);
    step();
    ex_valid = 1'b0; settle();
    chk("beq_rv_N1", 64'(redirect_valid), 64'd1);
    chk("beq_pc_N1", 64'(redirect_pc), 64'h40);
    chk("beq_sq_N1", 64'(squash), 64'd1);
    step(); settle();
    chk("beq_rv_N2", 64'(redirect_valid), 64'd0);
    chk("beq_sq_N2", 64'(squash), 64'd1);
    step(); settle();
    chk("beq_sq_N3", 64'(squash), 64'd1);
    step(); settle();
    chk("beq_sq_N4", 64'(squash), 64'd0);
    chk_cnt("beq", 1, 1);

    // BLTU not taken
    ex_valid = 1'b1; ex_branch = 1'b1; ex_funct3 = 3'b110; eq = 1'b0; lt = 1'b0;
    settle();
    chk("bltu_un", 64'(br_un), 64'd1);
    chk("bltu_sq", 64'(squash), 64'd0);
    step();
    ex_valid = 1'b0; settle();
    chk("bltu_rv", 64'(redirect_valid), 64'd0);
    chk("bltu_sq2", 64'(squash), 64'd0);
    chk_cnt("bltu", 2, 1);

    // JAL with fetch not ready for 3 cycles; reserved funct3 bits must not flag
    ex_valid = 1'b1; ex_branch = 1'b0; ex_jump = 1'b1; ex_funct3 = 3'b010;
    ex_target = 32'h0000_1234; redirect_ready = 1'b0;
    settle();
    chk("jal_sq", 64'(squash), 64'd1);
    step();
    ex_valid = 1'b0; ex_jump = 1'b0; ex_funct3 = 3'b000; ex_target = 32'hdead_beef;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("jal_hold_rv", 64'(redirect_valid), 64'd1);
      chk("jal_hold_pc", 64'(redirect_pc), 64'h1234);
      chk("jal_no_ill", 64'(br_illegal), 64'd0);
      step();
    end
    redirect_ready = 1'b1; settle();
    chk("jal_rdy_rv", 64'(redirect_valid), 64'd1);
    step(); settle();
    chk("jal_flush_rv", 64'(redirect_valid), 64'd0);
    chk("jal_flush_sq", 64'(squash), 64'd1);
    step(); step(); settle();
    chk("jal_idle_sq", 64'(squash), 64'd0);
    chk_cnt("jal", 2, 2);

    // Taken BEQ, then a wrong-path BNE sitting in EX during REDIRECT/FLUSH
    ex_valid = 1'b1; ex_branch = 1'b1; ex_funct3 = 3'b000; eq = 1'b1;
    ex_target = 32'h0000_0080; redirect_ready = 1'b0;
    step();
    ex_funct3 = 3'b001; eq = 1'b0; ex_target = 32'h0000_0100;
    settle();
    chk("wp_rv", 64'(redirect_valid), 64'd1);
    chk("wp_pc", 64'(redirect_pc), 64'h80);
    step(); settle();
    chk("wp_pc2", 64'(redirect_pc), 64'h80);
    redirect_ready = 1'b1;
    step(); settle();
    chk("wp_fl_rv", 64'(redirect_valid), 64'd0);
    step(); settle();
    chk("wp_fl_rv2", 64'(redirect_valid), 64'd0);
    chk("wp_fl_sq", 64'(squash), 64'd1);
    ex_valid = 1'b0;
    step(); settle();
    chk("wp_idle_sq", 64'(squash), 64'd0);
    chk("wp_idle_rv", 64'(redirect_valid), 64'd0);
    chk_cnt("wp", 3, 3);

    // Reserved funct3 held under stall: no pulse until stall drops
    ex_valid = 1'b1; ex_branch = 1'b1; ex_funct3 = 3'b010; stall = 1'b1;
    settle();
    chk("ill_st_sq", 64'(squash), 64'd0);
    step(); settle();
    chk("ill_st_p1", 64'(br_illegal), 64'd0);
    step(); settle();
    chk("ill_st_p2", 64'(br_illegal), 64'd0);
    stall = 1'b0; #1;
    chk("ill_sq", 64'(squash), 64'd0);
    step();
    ex_valid = 1'b0; settle();
    chk("ill_pulse", 64'(br_illegal), 64'd1);
    chk("ill_rv", 64'(redirect_valid), 64'd0);
    step(); settle();
    chk("ill_pulse_end", 64'(br_illegal), 64'd0);
    chk_cnt("ill", 4, 3);

    // Reset while in REDIRECT
    ex_valid = 1'b1; ex_branch = 1'b1; ex_funct3 = 3'b001; eq = 1'b0;
    ex_target = 32'h0000_0200; redirect_ready = 1'b0;
    step();
    ex_valid = 1'b0; settle();
    chk("rr_rv", 64'(redirect_valid), 64'd1);
    rst_n = 1'b0;
    step(); settle();
    chk("rr_rv0", 64'(redirect_valid), 64'd0);
    chk("rr_sq0", 64'(squash), 64'd0);
    chk("rr_pc0", 64'(redirect_pc), 64'd0);
    chk_cnt("rr", 0, 0);
    rst_n = 1'b1; redirect_ready = 1'b1;
    step(); settle();
    chk("rr_idle_rdy", 64'(redirect_valid), 64'd0);
    chk("rr_idle_sq", 64'(squash), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
